tm1638_serial_tx: RTL and testbench

Byte-level serial transmitter for the TM1638 LED/key board. It consumes the 781.25 kHz square wave from the TM1638 clock divider as its bit-rate reference and generates STB/CLK/DIO. Bytes are sent LSB first, one frame per STB-low window. An upstream sequencer feeds command and data bytes through a valid/ready handshake. Write-only; key readback is out of scope.

---
 rtl/tm1638_pkg.sv | 22 ++
 rtl/clk_tick_sync.sv | 25 ++
 rtl/tm1638_serial_tx.sv | 146 ++++++++++++++
 tb/tb_tm1638_serial_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// Shared types and command constants for the TM1638 serial interface.
package tm1638_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StBitLo,
    StBitHi,
    StGap,
    StStop,
    StHold
  } tx_state_e;

  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISP_ON    = 8'h88;

  function automatic logic [7:0] disp_on_cmd(input logic [2:0] brightness);
    return CMD_DISP_ON | {5'b0, brightness};
  endfunction

endpackage

// File: rtl/clk_tick_sync.sv
// Synchronises a slow divided clock and emits a one-cycle pulse on its rising edge.
module clk_tick_sync (
  input  logic clki,
  input  logic rst_n,
  input  logic clk_in,
  output logic tick
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= clk_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/tm1638_serial_tx.sv
// Byte-level STB/CLK/DIO transmitter for the TM1638, LSB first, paced by divider ticks.
module tm1638_serial_tx
  import tm1638_pkg::*;
#(
  parameter int unsigned STB_HIGH_TICKS = 2,
  parameter int unsigned TICK_CNT_W     = 4
) (
  input  logic       clki,
  input  logic       rst_n,
  input  logic       clk_khz,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       busy,
  output logic       tm_stb,
  output logic       tm_clk,
  output logic       tm_dio
);

  localparam logic [TICK_CNT_W-1:0] HoldMax = TICK_CNT_W'(STB_HIGH_TICKS);

  logic tick;

  clk_tick_sync u_tick_sync (
    .clki   (clki),
    .rst_n  (rst_n),
    .clk_in (clk_khz),
    .tick   (tick)
  );

  tx_state_e             state_q, state_d;
  logic [7:0]            sh_q, sh_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic [TICK_CNT_W-1:0] hold_q, hold_d;
  logic                  stb_q, stb_d, clk_q, clk_d, dio_q, dio_d;
  logic                  ready_q, ready_d, busy_q, busy_d;
  logic                  accept;

  assign accept = tx_valid & ready_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    hold_d  = hold_q;
    stb_d   = stb_q;
    clk_d   = clk_q;
    dio_d   = dio_q;

    // Loading is shared by IDLE and GAP; only the state guards whether it is used.
    if (accept) begin
      sh_d   = tx_data;
      last_d = tx_last;
      cnt_d  = 3'd0;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          stb_d   = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup, StBitLo: begin
        if (tick) begin
          clk_d   = 1'b0;
          dio_d   = sh_q[0];
          state_d = StBitHi;
        end
      end
      StBitHi: begin
        if (tick) begin
          clk_d = 1'b1;
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = last_q ? StStop : StGap;
          end else begin
            state_d = StBitLo;
          end
        end
      end
      StGap: begin
        if (accept) begin
          state_d = StSetup;
        end
      end
      StStop: begin
        if (tick) begin
          stb_d   = 1'b1;
          dio_d   = 1'b1;
          hold_d  = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (tick) begin
          hold_d = hold_q + 1'b1;
          if (hold_d == HoldMax) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle) || (state_d == StGap);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_q    <= 8'd0;
      cnt_q   <= 3'd0;
      last_q  <= 1'b0;
      hold_q  <= '0;
      stb_q   <= 1'b1;
      clk_q   <= 1'b1;
      dio_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      stb_q   <= stb_d;
      clk_q   <= clk_d;
      dio_q   <= dio_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign tm_stb   = stb_q;
  assign tm_clk   = clk_q;
  assign tm_dio   = dio_q;

endmodule

// File: tb/tb_tm1638_serial_tx.sv
// Directed self-checking bench for tm1638_serial_tx; one divider tick per 64 clki cycles.
module tb_tm1638_serial_tx;

  logic       clki     = 1'b0;
  logic       rst_n    = 1'b0;
  logic       clk_khz  = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_last  = 1'b0;
  logic       tx_ready, busy, tm_stb, tm_clk, tm_dio;

  tm1638_serial_tx u_dut (
    .clki     (clki),
    .rst_n    (rst_n),
    .clk_khz  (clk_khz),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .busy     (busy),
    .tm_stb   (tm_stb),
    .tm_clk   (tm_clk),
    .tm_dio   (tm_dio)
  );

  always #5 clki = ~clki;
  always #320 clk_khz = ~clk_khz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: samples 2 ns after each clki edge.
  int   cyc = 0;
  logic cap_bits [64];
  int   cap_n = 0;
  int   last_rise_cyc = 0;
  int   stb_rises = 0, stb_falls = 0;
  int   stb_rise_cyc = 0, stb_fall_cyc = 0;
  logic prev_clk = 1'b1, prev_stb = 1'b1;

  always @(posedge clki) cyc <= cyc + 1;

  always begin
    @(posedge clki);
    #2;
    if (rst_n && tm_clk && !prev_clk) begin
      if (cap_n < 64) cap_bits[cap_n] = tm_dio;
      cap_n++;
      last_rise_cyc = cyc;
    end
    if (tm_stb && !prev_stb) begin
      stb_rises++;
      stb_rise_cyc = cyc;
    end
    if (!tm_stb && prev_stb) begin
      stb_falls++;
      stb_fall_cyc = cyc;
    end
    prev_clk = tm_clk;
    prev_stb = tm_stb;
  end

  task automatic clear_mon();
    cap_n     = 0;
    stb_rises = 0;
    stb_falls = 0;
  endtask

  function automatic logic [7:0] get_byte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (base + i < 64) ? cap_bits[base + i] : 1'b0;
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] data, input logic last, input string tag);
    int n = 0;
    @(negedge clki);
    while (!tx_ready && n < 5000) begin
      @(negedge clki);
      n++;
    end
    check({tag, "_ready"}, 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = data;
    tx_last  = last;
    @(posedge clki);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int ready_busy);
    int n = 0;
    ready_busy = 0;
    @(negedge clki);
    while (busy && n < 4000) begin
      if (tx_ready) ready_busy++;
      @(negedge clki);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_edges(input int cnt, input string tag);
    int n = 0;
    while (cap_n < cnt && n < 4000) begin
      @(negedge clki);
      n++;
    end
    check({tag, "_edges_reached"}, 32'(cap_n >= cnt), 32'd1);
  endtask

  initial begin
    int rb;
    int viol;
    int n;
    int edges0;

    repeat (4) @(negedge clki);
    check("rst_stb", 32'(tm_stb), 32'd1);
    check("rst_clk", 32'(tm_clk), 32'd1);
    check("rst_dio", 32'(tm_dio), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clki);

    // 1: single byte 0x44
    clear_mon();
    send_byte(8'h44, 1'b1, "t1");
    check("t1_stb_low", 32'(tm_stb), 32'd0);
    check("t1_ready_low", 32'(tx_ready), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_idle("t1", rb);
    check("t1_edges", 32'(cap_n), 32'd8);
    check("t1_byte", 32'(get_byte(0)), 32'h44);
    check("t1_stb_rise_delay", 32'(stb_rise_cyc - last_rise_cyc), 32'd64);
    check("t1_ready_while_busy", 32'(rb), 32'd0);
    check("t1_stb_high", 32'(tm_stb), 32'd1);

    // 2: two-byte frame
    clear_mon();
    send_byte(8'hC0, 1'b0, "t2a");
    send_byte(8'h3F, 1'b1, "t2b");
    wait_idle("t2", rb);
    check("t2_edges", 32'(cap_n), 32'd16);
    check("t2_byte0", 32'(get_byte(0)), 32'hC0);
    check("t2_byte1", 32'(get_byte(8)), 32'h3F);
    check("t2_stb_rises", 32'(stb_rises), 32'd1);

    // 3: stall in GAP
    clear_mon();
    send_byte(8'hC0, 1'b0, "t3a");
    wait_edges(8, "t3");
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clki);
      n++;
    end
    edges0 = cap_n;
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clki);
      if (tx_ready !== 1'b1 || tm_stb !== 1'b0 || tm_clk !== 1'b1) viol++;
    end
    check("t3_gap_lines", 32'(viol), 32'd0);
    check("t3_no_edges", 32'(cap_n - edges0), 32'd0);
    send_byte(8'h5A, 1'b1, "t3b");
    wait_idle("t3", rb);
    check("t3_byte0", 32'(get_byte(0)), 32'hC0);
    check("t3_byte1", 32'(get_byte(8)), 32'h5A);
    check("t3_stb_rises", 32'(stb_rises), 32'd1);

    // 4: valid while busy is not consumed
    clear_mon();
    send_byte(8'h81, 1'b1, "t4");
    wait_edges(3, "t4");
    @(negedge clki);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tx_last  = 1'b1;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clki);
      if (tx_ready !== 1'b0) viol++;
    end
    tx_valid = 1'b0;
    check("t4_ready_blocked", 32'(viol), 32'd0);
    wait_idle("t4", rb);
    check("t4_edges", 32'(cap_n), 32'd8);
    check("t4_byte", 32'(get_byte(0)), 32'h81);
    repeat (200) @(negedge clki);
    check("t4_no_second_frame", 32'(busy), 32'd0);
    check("t4_stb_falls", 32'(stb_falls), 32'd1);

    // 5: reset mid-byte
    clear_mon();
    send_byte(8'h00, 1'b1, "t5a");
    wait_edges(3, "t5");
    @(negedge clki);
    rst_n = 1'b0;
    #1;
    check("t5_stb", 32'(tm_stb), 32'd1);
    check("t5_clk", 32'(tm_clk), 32'd1);
    check("t5_dio", 32'(tm_dio), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clki);
    rst_n = 1'b1;
    repeat (2) @(negedge clki);
    clear_mon();
    send_byte(8'h3C, 1'b1, "t5b");
    wait_idle("t5", rb);
    check("t5_edges", 32'(cap_n), 32'd8);
    check("t5_byte", 32'(get_byte(0)), 32'h3C);

    // 6: back-to-back frames with valid held
    clear_mon();
    @(negedge clki);
    tx_valid = 1'b1;
    tx_data  = 8'h96;
    tx_last  = 1'b1;
    n = 0;
    while (stb_falls < 2 && n < 5000) begin
      @(negedge clki);
      n++;
    end
    tx_valid = 1'b0;
    check("t6_two_frames", 32'(stb_falls), 32'd2);
    check("t6_stb_high_cycles", 32'(stb_fall_cyc - stb_rise_cyc), 32'd129);
    wait_idle("t6", rb);
    check("t6_edges", 32'(cap_n), 32'd16);
    check("t6_byte0", 32'(get_byte(0)), 32'h96);
    check("t6_byte1", 32'(get_byte(8)), 32'h96);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
